// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Parametrised multi-digit BCD modulo counter with count enable, up/down
//   direction, synchronous load and a single-cycle wrap pulse. Instances chain
//   through tc -> en of the next stage to build time-of-day or countdown chains.
//
//   Optional feature macro: BCD_LOAD_CHECK_EN
//     defined   : a load is accepted only if every digit is <= 9 and the value
//                 is below MODULUS; a rejected load holds count and pulses load_err.
//     undefined : load_val is loaded verbatim and load_err is tied to 0.
//
// Parameters
//   DIGITS   number of BCD digits (1..4); count width is 4*DIGITS
//   MODULUS  count range 0..MODULUS-1 (2..10**DIGITS)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   en        in   count enable, one step per clk while high
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   synchronous load strobe (beats en)
//   load_val  in   BCD value to load
//   count     out  registered BCD count, digit 0 = bits [3:0]
//   carry     out  registered one-cycle wrap pulse
//   tc        out  combinational terminal count, for ripple-enabling the next stage
//   load_err  out  registered one-cycle rejected-load pulse
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // Digits 10..15 (only reachable through an unchecked load) behave as 9.
  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] n);
    logic [W-1:0] r;
    r = n;
    for (int i = 0; i < DIGITS; i++) begin
      if (n[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] n);
    logic [W-1:0] r;
    logic         c;
    r = n;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (n[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = n[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] n);
    logic [W-1:0] r;
    logic         b;
    r = n;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (n[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = n[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic [W-1:0] count_n;
  logic         at_max;
  logic         at_zero;
  logic         load_ok;
  logic         err_d;

  // With normalised digits, an unsigned vector compare is a BCD numeric compare.
  assign count_n = bcd_sat(count_q);
  assign at_max  = (count_n >= MAX_BCD);
  assign at_zero = (count_q == '0);

`ifdef BCD_LOAD_CHECK_EN
  always_comb begin
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end
`else
  assign load_ok = 1'b1;
`endif

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         err_d   = 1'b1;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = bcd_inc(count_n);
        end
      end else begin
        if (at_zero) begin
          count_d = MAX_BCD;
          carry_d = 1'b1;
        end else begin
          count_d = bcd_dec(count_n);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

`ifdef BCD_LOAD_CHECK_EN
  logic load_err_q;

  always_ff @(posedge clk) begin
    if (!reset) load_err_q <= 1'b0;
    else        load_err_q <= err_d;
  end

  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  assign count = count_q;
  assign carry = carry_q;
  assign tc    = en & (up ? (count_n == MAX_BCD) : at_zero);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter. Three instances share stimulus:
//   k=0: DIGITS=2, MODULUS=24   k=1: DIGITS=2, MODULUS=100   k=2: DIGITS=1, MODULUS=2
// The reference model works on plain integers derived from the counting rules.
module tb_bcd_mod_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] lv;

  logic [7:0]  cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        cy_a, cy_b, cy_c;
  logic        tc_a, tc_b, tc_c;
  logic        er_a, er_b, er_c;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0][15:0] cnt;
    logic [2:0]       cy;
    logic [2:0]       er;
  } exp_t;

  exp_t sbq[$];

  logic [2:0][15:0] m_cnt;

  always #5 clk = ~clk;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .count(cnt_a), .carry(cy_a), .tc(tc_a), .load_err(er_a));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(100)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .count(cnt_b), .carry(cy_b), .tc(tc_b), .load_err(er_b));

  bcd_mod_counter #(.DIGITS(1), .MODULUS(2)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .count(cnt_c), .carry(cy_c), .tc(tc_c), .load_err(er_c));

  function automatic int nd_of(int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic int md_of(int k);
    return (k == 0) ? 24 : ((k == 1) ? 100 : 2);
  endfunction

  function automatic logic [15:0] mask_of(int k);
    return (k == 2) ? 16'h000F : 16'h00FF;
  endfunction

  // Integer value of a BCD word with digits above 9 read as 9.
  function automatic int sat_val(logic [15:0] c, int nd);
    int v;
    int d;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'(c[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd16(int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(logic [15:0] c, int nd);
    for (int i = 0; i < nd; i++) begin
      if (c[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(string name, int k, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] @%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, queue the expectation.
  task automatic cyc(bit r, bit e, bit u, bit l, logic [15:0] v);
    exp_t        x;
    logic [15:0] lvk;
    int          val;
    bit          accept;
    #1;
    reset = r; en = e; up = u; load = l; lv = v;
    @(posedge clk);
    x = '0;
    for (int k = 0; k < 3; k++) begin
      lvk = v & mask_of(k);
      if (!r) begin
        m_cnt[k] = '0;
      end else if (l) begin
        accept = 1'b1;
`ifdef BCD_LOAD_CHECK_EN
        accept = digits_ok(lvk, nd_of(k)) && (sat_val(lvk, nd_of(k)) < md_of(k));
`endif
        if (accept) m_cnt[k] = lvk;
        else        x.er[k]  = 1'b1;
      end else if (e) begin
        val = sat_val(m_cnt[k], nd_of(k));
        if (u) begin
          if (val >= md_of(k) - 1) begin
            m_cnt[k] = '0;
            x.cy[k]  = 1'b1;
          end else begin
            m_cnt[k] = to_bcd16(val + 1);
          end
        end else begin
          if (val == 0) begin
            m_cnt[k] = to_bcd16(md_of(k) - 1);
            x.cy[k]  = 1'b1;
          end else begin
            m_cnt[k] = to_bcd16(val - 1);
          end
        end
      end
      x.cnt[k] = m_cnt[k];
    end
    sbq.push_back(x);
  endtask

  // Monitor: one expectation per clock, compared on the falling edge.
  initial begin
    exp_t        e;
    logic [15:0] ac;
    logic        acy, aer, atc;
    bit          etc;
    int          v;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < 3; k++) begin
          case (k)
            0:       begin ac = {8'h00, cnt_a};  acy = cy_a; aer = er_a; atc = tc_a; end
            1:       begin ac = {8'h00, cnt_b};  acy = cy_b; aer = er_b; atc = tc_b; end
            default: begin ac = {12'h000, cnt_c}; acy = cy_c; aer = er_c; atc = tc_c; end
          endcase
          v   = sat_val(e.cnt[k], nd_of(k));
          etc = en && (up ? (v == md_of(k) - 1) : (v == 0));
          chk("count",    k, ac,                e.cnt[k]);
          chk("carry",    k, {15'h0, acy},      {15'h0, e.cy[k]});
          chk("load_err", k, {15'h0, aer},      {15'h0, e.er[k]});
          chk("tc",       k, {15'h0, atc},      {15'h0, etc});
        end
      end
    end
  end

  initial begin
    logic [15:0] rv;
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; lv = 16'h0077;
    m_cnt = '0;

    // Reset held with en and load asserted.
    cyc(0, 1, 1, 1, 16'h0077);
    cyc(0, 1, 1, 1, 16'h0077);
    // Free-running up count through the wrap.
    for (int i = 0; i < 30; i++) cyc(1, 1, 1, 0, 16'h0000);
    // Load 05 then count down through zero.
    cyc(1, 0, 1, 1, 16'h0005);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 16'h0000);
    // Enable toggling from 08, then load with en high.
    cyc(1, 0, 1, 1, 16'h0008);
    cyc(1, 1, 1, 0, 16'h0000);
    cyc(1, 0, 1, 0, 16'h0000);
    cyc(1, 1, 1, 0, 16'h0000);
    cyc(1, 0, 1, 0, 16'h0000);
    cyc(1, 1, 1, 1, 16'h0019);
    cyc(1, 0, 1, 0, 16'h0000);
    // Invalid-digit and out-of-range loads, then a step from the loaded value.
    cyc(1, 1, 1, 1, 16'h001A);
    cyc(1, 0, 1, 0, 16'h0000);
    cyc(1, 1, 1, 1, 16'h0024);
    cyc(1, 0, 1, 1, 16'h0023);
    cyc(1, 0, 1, 1, 16'h001A);
    cyc(1, 1, 1, 0, 16'h0000);
    cyc(1, 1, 1, 0, 16'h0000);
    // Full-range wraps both ways.
    cyc(1, 0, 1, 1, 16'h0099);
    cyc(1, 1, 1, 0, 16'h0000);
    cyc(1, 1, 0, 0, 16'h0000);
    cyc(1, 1, 0, 0, 16'h0000);
    cyc(1, 1, 0, 0, 16'h0000);
    // Reset in the middle of counting.
    cyc(1, 0, 1, 1, 16'h0021);
    cyc(1, 1, 1, 0, 16'h0000);
    cyc(0, 1, 1, 0, 16'h0000);
    cyc(1, 1, 1, 0, 16'h0000);
    cyc(1, 1, 1, 0, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 3) == 0) rv[4*d +: 4] = 4'($urandom_range(0, 15));
        else                           rv[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, rv);
    end

    #1;
    en = 1'b0; load = 1'b0; reset = 1'b1;
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0 pending expectations", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
